// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg
//   Shared types and constants for the write-back stage slice.
//   wb_entry_t   : one APU result buffer entry (valid flag, destination, data)
//   WB_DEPTH_MAX : largest supported APU result buffer depth
//   WB_PTR_W     : pointer width that covers WB_DEPTH_MAX entries
//   WB_CNT_W     : occupancy counter width that covers 0..WB_DEPTH_MAX
//   wb_ptr_inc() : pointer increment that wraps modulo an arbitrary depth
package cv32e40p_pkg;

  localparam int WB_DEPTH_MAX = 4;
  localparam int WB_PTR_W     = $clog2(WB_DEPTH_MAX);
  localparam int WB_CNT_W     = $clog2(WB_DEPTH_MAX + 1);

  typedef struct packed {
    logic        valid;
    logic [5:0]  waddr;
    logic [31:0] wdata;
  } wb_entry_t;

  // Depth need not be a power of two, so wrap explicitly instead of relying on overflow.
  function automatic logic [WB_PTR_W-1:0] wb_ptr_inc(input logic [WB_PTR_W-1:0] ptr,
                                                     input int                  depth);
    return (ptr == WB_PTR_W'(depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/cv32e40p_wb_fifo.sv
// cv32e40p_wb_fifo
//   APU result buffer for the write-back stage. Holds up to DEPTH results that lost
//   register-file port arbitration, invalidates entries overwritten by newer LSU writes,
//   and flags RAW hazards of ID-stage sources against valid entries.
// Parameters
//   DEPTH   buffer entries, 2..WB_DEPTH_MAX
//   ADDR_W  register address width (entries store 6-bit addresses)
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i/_waddr/_wdata write a new valid entry at the tail
//   pop_i               retire the head entry (caller guarantees non-empty)
//   kill_i/kill_waddr_i invalidate every valid entry whose address matches
//   id_raddr_i/_valid_i ID-stage source addresses for hazard compare
//   head_o              current head entry
//   count_o             occupied slots, including invalidated ones
//   dep_o               some valid source matches a valid entry
module cv32e40p_wb_fifo
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [ADDR_W-1:0]        push_waddr_i,
  input  logic [31:0]              push_wdata_i,
  input  logic                     pop_i,
  input  logic                     kill_i,
  input  logic [ADDR_W-1:0]        kill_waddr_i,
  input  logic [2:0][ADDR_W-1:0]   id_raddr_i,
  input  logic [2:0]               id_raddr_valid_i,
  output wb_entry_t                head_o,
  output logic [WB_CNT_W-1:0]      count_o,
  output logic                     dep_o
);

  wb_entry_t             entries_q [DEPTH];
  logic [WB_PTR_W-1:0]   head_q;
  logic [WB_PTR_W-1:0]   tail_q;
  logic [WB_CNT_W-1:0]   count_q;

  // Later assignments win: a push into the slot being popped (full buffer with pop)
  // overwrites the cleared head, and a pop clears the valid bit of an entry that was
  // already killed without any conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_i && entries_q[i].valid && (entries_q[i].waddr == 6'(kill_waddr_i))) begin
          entries_q[i].valid <= 1'b0;
        end
        if (pop_i && (WB_PTR_W'(i) == head_q)) begin
          entries_q[i].valid <= 1'b0;
        end
        if (push_i && (WB_PTR_W'(i) == tail_q)) begin
          entries_q[i] <= '{valid: 1'b1, waddr: 6'(push_waddr_i), wdata: push_wdata_i};
        end
      end

      if (pop_i) begin
        head_q <= wb_ptr_inc(head_q, DEPTH);
      end
      if (push_i) begin
        tail_q <= wb_ptr_inc(tail_q, DEPTH);
      end

      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Pointer-compare mux keeps every array access in range for non-power-of-two depths.
  always_comb begin
    head_o = '0;
    dep_o  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (WB_PTR_W'(i) == head_q) begin
        head_o = entries_q[i];
      end
      for (int s = 0; s < 3; s++) begin
        if (entries_q[i].valid && id_raddr_valid_i[s] &&
            (ADDR_W'(entries_q[i].waddr) == id_raddr_i[s])) begin
          dep_o = 1'b1;
        end
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cv32e40p_wb_stage.sv
// cv32e40p_wb_stage
//   Write-back stage downstream of EX. Owns register-file write port A and merges the
//   LSU result stream with APU results. APU results that lose arbitration go into a small
//   buffer (cv32e40p_wb_fifo) rather than stalling EX.
//   Port priority: LSU write, then buffer head, then APU bypass.
// Configuration
//   CV32E40P_WB_PERF_EN defined   : perf_wb_stall_o counts cycles with a non-empty buffer
//   CV32E40P_WB_PERF_EN undefined : perf_wb_stall_o tied to zero, no counter built
// Parameters
//   DEPTH 2..4 buffer entries, ADDR_W register address width
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   lsu_we_i/_waddr_i/_wdata_i         LSU/EX-port write request
//   apu_valid_i/_waddr_i/_result_i     APU result pulse, cannot be refused
//   id_raddr_i/id_raddr_valid_i        ID-stage sources for hazard check
//   rf_we_o/rf_waddr_o/rf_wdata_o      registered register-file port A
//   wb_ready_o                         EX may issue a new instruction
//   wb_dep_o                           ID source hits a valid buffered result
//   wb_overflow_o                      sticky: APU result dropped on a full buffer
//   perf_wb_stall_o                    buffer-occupied cycle counter
module cv32e40p_wb_stage
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     lsu_we_i,
  input  logic [ADDR_W-1:0]        lsu_waddr_i,
  input  logic [31:0]              lsu_wdata_i,
  input  logic                     apu_valid_i,
  input  logic [ADDR_W-1:0]        apu_waddr_i,
  input  logic [31:0]              apu_result_i,
  input  logic [2:0][ADDR_W-1:0]   id_raddr_i,
  input  logic [2:0]               id_raddr_valid_i,
  output logic                     rf_we_o,
  output logic [ADDR_W-1:0]        rf_waddr_o,
  output logic [31:0]              rf_wdata_o,
  output logic                     wb_ready_o,
  output logic                     wb_dep_o,
  output logic                     wb_overflow_o,
  output logic [31:0]              perf_wb_stall_o
);

  wb_entry_t            head;
  logic [WB_CNT_W-1:0]  count;
  logic                 buf_nonempty;
  logic                 buf_full;
  logic                 head_live;
  logic                 pop;
  logic                 push;
  logic                 apu_bypass;
  logic                 apu_offer;
  logic                 drop;
  logic                 wr_we;
  logic [ADDR_W-1:0]    wr_waddr;
  logic [31:0]          wr_wdata;

  assign buf_nonempty = (count != '0);
  assign buf_full     = (count == WB_CNT_W'(DEPTH));
  assign head_live    = buf_nonempty && head.valid;

  // A killed head retires without needing the port, so it drains even under an LSU write.
  assign pop        = buf_nonempty && (!head.valid || !lsu_we_i);
  assign apu_bypass = apu_valid_i && !lsu_we_i && !head_live;
  assign apu_offer  = apu_valid_i && !apu_bypass;
  assign push       = apu_offer && (!buf_full || pop);
  assign drop       = apu_offer && buf_full && !pop;

  always_comb begin
    wr_we    = 1'b0;
    wr_waddr = lsu_waddr_i;
    wr_wdata = lsu_wdata_i;
    if (lsu_we_i) begin
      wr_we = 1'b1;
    end else if (head_live) begin
      wr_we    = 1'b1;
      wr_waddr = ADDR_W'(head.waddr);
      wr_wdata = head.wdata;
    end else if (apu_valid_i) begin
      wr_we    = 1'b1;
      wr_waddr = apu_waddr_i;
      wr_wdata = apu_result_i;
    end
  end

  cv32e40p_wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk              (clk),
    .rst_n            (rst_n),
    .push_i           (push),
    .push_waddr_i     (apu_waddr_i),
    .push_wdata_i     (apu_result_i),
    .pop_i            (pop),
    .kill_i           (lsu_we_i),
    .kill_waddr_i     (lsu_waddr_i),
    .id_raddr_i       (id_raddr_i),
    .id_raddr_valid_i (id_raddr_valid_i),
    .head_o           (head),
    .count_o          (count),
    .dep_o            (wb_dep_o)
  );

  // Address/data hold their last written value on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_o       <= 1'b0;
      rf_waddr_o    <= '0;
      rf_wdata_o    <= '0;
      wb_overflow_o <= 1'b0;
    end else begin
      rf_we_o <= wr_we;
      if (wr_we) begin
        rf_waddr_o <= wr_waddr;
        rf_wdata_o <= wr_wdata;
      end
      if (drop) begin
        wb_overflow_o <= 1'b1;
      end
    end
  end

  // One slot stays reserved for the APU op that may already be in flight.
  assign wb_ready_o = (count < WB_CNT_W'(DEPTH - 1));

`ifdef CV32E40P_WB_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (buf_nonempty) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_wb_stall_o = perf_q;
`else
  assign perf_wb_stall_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_wb_stage.sv
// tb_cv32e40p_wb_stage
//   Table-driven bench for cv32e40p_wb_stage (DEPTH=2). Each vector is driven on a falling
//   edge, captured by the following rising edge, and its expected outputs are compared on
//   the next falling edge (wb_dep_o against the same ID inputs, post-edge buffer state).
//   Hand-written sequences cover the performance counter and a mid-stream reset.
//   Honours CV32E40P_WB_PERF_EN for the expected perf_wb_stall_o value.
module tb_cv32e40p_wb_stage;

  logic            clk;
  logic            rst_n;
  logic            lsu_we;
  logic [5:0]      lsu_waddr;
  logic [31:0]     lsu_wdata;
  logic            apu_valid;
  logic [5:0]      apu_waddr;
  logic [31:0]     apu_result;
  logic [2:0][5:0] id_raddr;
  logic [2:0]      id_raddr_valid;
  logic            rf_we;
  logic [5:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic            wb_ready;
  logic            wb_dep;
  logic            wb_overflow;
  logic [31:0]     perf_wb_stall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        lsu_we;
    logic [5:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        apu_valid;
    logic [5:0]  apu_waddr;
    logic [31:0] apu_result;
    logic [5:0]  raddr;
    logic        rvalid;
    int          src;
    logic        e_we;
    logic [5:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_ready;
    logic        e_dep;
    logic        e_ovf;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  cv32e40p_wb_stage #(
    .DEPTH  (2),
    .ADDR_W (6)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lsu_we_i         (lsu_we),
    .lsu_waddr_i      (lsu_waddr),
    .lsu_wdata_i      (lsu_wdata),
    .apu_valid_i      (apu_valid),
    .apu_waddr_i      (apu_waddr),
    .apu_result_i     (apu_result),
    .id_raddr_i       (id_raddr),
    .id_raddr_valid_i (id_raddr_valid),
    .rf_we_o          (rf_we),
    .rf_waddr_o       (rf_waddr),
    .rf_wdata_o       (rf_wdata),
    .wb_ready_o       (wb_ready),
    .wb_dep_o         (wb_dep),
    .wb_overflow_o    (wb_overflow),
    .perf_wb_stall_o  (perf_wb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic lw, input logic [5:0] la, input logic [31:0] ld,
                              input logic av, input logic [5:0] aa, input logic [31:0] ad,
                              input logic [5:0] ra, input logic rv, input int src,
                              input logic ewe, input logic [5:0] ea, input logic [31:0] ed,
                              input logic erdy, input logic edep, input logic eovf);
    vec_t v;
    v.lsu_we = lw;  v.lsu_waddr = la;  v.lsu_wdata = ld;
    v.apu_valid = av;  v.apu_waddr = aa;  v.apu_result = ad;
    v.raddr = ra;  v.rvalid = rv;  v.src = src;
    v.e_we = ewe;  v.e_waddr = ea;  v.e_wdata = ed;
    v.e_ready = erdy;  v.e_dep = edep;  v.e_ovf = eovf;
    return v;
  endfunction

  task automatic checkValue(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic driveIdle();
    lsu_we = 1'b0;  lsu_waddr = '0;  lsu_wdata = '0;
    apu_valid = 1'b0;  apu_waddr = '0;  apu_result = '0;
    id_raddr = '0;  id_raddr_valid = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    lsu_we = v.lsu_we;  lsu_waddr = v.lsu_waddr;  lsu_wdata = v.lsu_wdata;
    apu_valid = v.apu_valid;  apu_waddr = v.apu_waddr;  apu_result = v.apu_result;
    id_raddr = '0;
    id_raddr_valid = '0;
    id_raddr[v.src] = v.raddr;
    id_raddr_valid[v.src] = v.rvalid;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkValue("rf_we", idx, 32'(rf_we), 32'(v.e_we));
    if (v.e_we) begin
      checkValue("rf_waddr", idx, 32'(rf_waddr), 32'(v.e_waddr));
      checkValue("rf_wdata", idx, rf_wdata, v.e_wdata);
    end
    checkValue("wb_ready", idx, 32'(wb_ready), 32'(v.e_ready));
    checkValue("wb_dep", idx, 32'(wb_dep), 32'(v.e_dep));
    checkValue("wb_overflow", idx, 32'(wb_overflow), 32'(v.e_ovf));
  endtask

  task automatic runVector(input int idx);
    applyStimulus(vecs[idx]);
    @(negedge clk);
    checkOutput(vecs[idx], idx);
  endtask

  initial begin
    //                lw la  ld            av aa  ad             ra  rv s   we ea  ed            rdy dep ovf
    vecs[0]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        0,  0, 0,  0, 0,  32'h0,        1, 0, 0);
    // LSU only
    vecs[1]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0,  0, 0,  1, 5,  32'hDEADBEEF, 1, 0, 0);
    // collision: LSU wins, APU buffered, then drained
    vecs[2]  = mk(1, 3,  32'h33,       1, 7,  32'h1234,     7,  1, 0,  1, 3,  32'h33,       0, 1, 0);
    vecs[3]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        7,  1, 0,  1, 7,  32'h1234,     1, 0, 0);
    // fill under continuous LSU writes, third APU result overflows
    vecs[4]  = mk(1, 1,  32'h11,       1, 10, 32'hA0,       10, 1, 0,  1, 1,  32'h11,       0, 1, 0);
    vecs[5]  = mk(1, 2,  32'h22,       1, 11, 32'hB1,       11, 1, 2,  1, 2,  32'h22,       0, 1, 0);
    vecs[6]  = mk(1, 4,  32'h44,       1, 12, 32'hC2,       12, 1, 0,  1, 4,  32'h44,       0, 0, 1);
    vecs[7]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        12, 1, 1,  1, 10, 32'hA0,       0, 0, 1);
    vecs[8]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        11, 1, 0,  1, 11, 32'hB1,       1, 0, 1);
    vecs[9]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        12, 1, 0,  0, 0,  32'h0,        1, 0, 1);
    // simultaneous pop and push across pointer wrap
    vecs[10] = mk(1, 20, 32'h20,       1, 21, 32'h2100,     21, 1, 0,  1, 20, 32'h20,       0, 1, 1);
    vecs[11] = mk(0, 0,  32'h0,        1, 22, 32'h2200,     22, 1, 1,  1, 21, 32'h2100,     0, 1, 1);
    vecs[12] = mk(0, 0,  32'h0,        1, 23, 32'h2300,     21, 1, 0,  1, 22, 32'h2200,     0, 0, 1);
    vecs[13] = mk(0, 0,  32'h0,        0, 0,  32'h0,        23, 1, 2,  1, 23, 32'h2300,     1, 0, 1);
    // LSU kill of a buffered entry: stale value never written
    vecs[14] = mk(1, 30, 32'h30,       1, 9,  32'h999,      9,  1, 0,  1, 30, 32'h30,       0, 1, 1);
    vecs[15] = mk(1, 9,  32'h9009,     0, 0,  32'h0,        9,  1, 0,  1, 9,  32'h9009,     0, 0, 1);
    vecs[16] = mk(0, 0,  32'h0,        0, 0,  32'h0,        9,  1, 0,  0, 0,  32'h0,        1, 0, 1);
    // killed head drains while an APU result bypasses in the same cycle
    vecs[17] = mk(1, 31, 32'h31,       1, 13, 32'h1313,     0,  0, 0,  1, 31, 32'h31,       0, 0, 1);
    vecs[18] = mk(1, 13, 32'h1300,     0, 0,  32'h0,        13, 1, 0,  1, 13, 32'h1300,     0, 0, 1);
    vecs[19] = mk(0, 0,  32'h0,        1, 14, 32'h1414,     14, 1, 0,  1, 14, 32'h1414,     1, 0, 1);
    // address 0 is buffered like any other; invalid source does not flag a hazard
    vecs[20] = mk(1, 1,  32'h1,        1, 0,  32'hF0,       0,  1, 0,  1, 1,  32'h1,        0, 1, 1);
    vecs[21] = mk(1, 2,  32'h2,        0, 0,  32'h0,        0,  0, 0,  1, 2,  32'h2,        0, 0, 1);
    vecs[22] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0,  1, 1,  1, 0,  32'hF0,       1, 0, 1);

    rst_n = 1'b0;
    driveIdle();
    repeat (2) @(negedge clk);
    checkValue("reset_rf_we", -1, 32'(rf_we), 32'h0);
    checkValue("reset_rf_waddr", -1, 32'(rf_waddr), 32'h0);
    checkValue("reset_rf_wdata", -1, rf_wdata, 32'h0);
    checkValue("reset_wb_ready", -1, 32'(wb_ready), 32'h1);
    checkValue("reset_wb_dep", -1, 32'(wb_dep), 32'h0);
    checkValue("reset_wb_overflow", -1, 32'(wb_overflow), 32'h0);
    checkValue("reset_perf", -1, perf_wb_stall, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      runVector(i);
    end

    // exactly one buffer-occupied cycle so far (between vectors 2 and 3)
`ifdef CV32E40P_WB_PERF_EN
    checkValue("perf_after_collision", 3, perf_wb_stall, 32'd1);
`else
    checkValue("perf_after_collision", 3, perf_wb_stall, 32'd0);
`endif

    for (int i = 4; i < NVEC; i++) begin
      runVector(i);
    end

    // mid-stream reset with the buffer full
    driveIdle();
    lsu_we = 1'b1;  lsu_waddr = 6'd40;  lsu_wdata = 32'h40;
    apu_valid = 1'b1;  apu_waddr = 6'd41;  apu_result = 32'h41;
    @(negedge clk);
    lsu_waddr = 6'd42;  lsu_wdata = 32'h42;
    apu_waddr = 6'd43;  apu_result = 32'h43;
    @(negedge clk);
    checkValue("full_wb_ready", 100, 32'(wb_ready), 32'h0);
    driveIdle();
    id_raddr[0] = 6'd41;
    id_raddr_valid[0] = 1'b1;
    #1;
    checkValue("full_wb_dep", 100, 32'(wb_dep), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkValue("midrst_rf_we", 101, 32'(rf_we), 32'h0);
    checkValue("midrst_rf_waddr", 101, 32'(rf_waddr), 32'h0);
    checkValue("midrst_rf_wdata", 101, rf_wdata, 32'h0);
    checkValue("midrst_wb_ready", 101, 32'(wb_ready), 32'h1);
    checkValue("midrst_wb_dep", 101, 32'(wb_dep), 32'h0);
    checkValue("midrst_wb_overflow", 101, 32'(wb_overflow), 32'h0);
    checkValue("midrst_perf", 101, perf_wb_stall, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apu_valid = 1'b1;  apu_waddr = 6'd5;  apu_result = 32'h55;
    id_raddr[0] = 6'd5;
    @(negedge clk);
    checkValue("post_rst_rf_we", 102, 32'(rf_we), 32'h1);
    checkValue("post_rst_rf_waddr", 102, 32'(rf_waddr), 32'd5);
    checkValue("post_rst_rf_wdata", 102, rf_wdata, 32'h55);
    checkValue("post_rst_wb_ready", 102, 32'(wb_ready), 32'h1);
    checkValue("post_rst_wb_dep", 102, 32'(wb_dep), 32'h0);
    driveIdle();
    @(negedge clk);
    checkValue("post_rst_idle_we", 103, 32'(rf_we), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
